mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, giving the byte-address width of the attached byte-wide data memory (32 bytes).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit: a load/store request from the EX/MEM register is present.
REQ-005 The block SHALL have port req_write_i, input, 1 bit: 1 = store word, 0 = load word.
REQ-006 The block SHALL have port req_addr_i, input, 32 bits: byte address of the word.
REQ-007 The block SHALL have port req_data_i, input, 32 bits: store data.
REQ-008 The block SHALL have port stall_o, output, 1 bit: holds the pipeline.
REQ-009 The block SHALL have port rsp_valid_o, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port rsp_data_o, output, 32 bits: the assembled load word.
REQ-011 The block SHALL have port err_o, output, 1 bit: misaligned request flag, valid with rsp_valid_o.
REQ-012 The block SHALL have port mem_write_o, output, 1 bit; port mem_read_o, output, 1 bit; port mem_addr_o, output, 32 bits; port mem_data_o, output, 32 bits; these drive the data memory.
REQ-013 The block SHALL have port mem_data_i, input, 32 bits: data memory read data, of which only bits [7:0] are used.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS and DONE; a 2-bit byte counter cnt SHALL count within ACCESS.
REQ-015 In IDLE with req_valid_i=1, the block SHALL latch the request (write, addr, data), clear cnt and enter ACCESS at the next edge.
REQ-016 In ACCESS, mem_addr_o SHALL be zero-extended (req_addr latched + cnt) modulo 2^ADDR_W; base 30 accesses bytes 30, 31, 0, 1.
REQ-017 For a store, mem_write_o SHALL be 1 and mem_data_o SHALL be {24'b0, wdata[8*cnt+7:8*cnt]} (little-endian).
REQ-018 For a load, mem_read_o SHALL be 1 and mem_data_i[7:0] SHALL be captured into result byte cnt at the edge ending that cycle.
REQ-019 After cnt=3, the FSM SHALL enter DONE; DONE SHALL last exactly one cycle with rsp_valid_o=1, then return to IDLE.
REQ-020 rsp_data_o SHALL present the assembled load word in DONE and hold it until the next load completes; stores SHALL leave it unchanged.
REQ-021 stall_o SHALL equal (IDLE and req_valid_i) or ACCESS; it SHALL be 0 in DONE, giving 5 stalled cycles per access.
REQ-022 req_valid_i SHALL be ignored outside IDLE; a request still asserted in the DONE cycle SHALL NOT be re-accepted (DONE always returns to IDLE first).
REQ-023 Outside ACCESS, mem_write_o and mem_read_o SHALL be 0, and mem_addr_o and mem_data_o SHALL be 0.

Reset
REQ-024 With rst_i=0, the block SHALL immediately force state IDLE, cnt=0, latched request=0, rsp_data_o=0, rsp_valid_o=0 and err_o=0, independent of clk_i.
REQ-025 A reset during ACCESS SHALL abort the access, with mem_write_o dropping at once; bytes already written SHALL remain written.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined, a request with req_addr_i[1:0]!=0 SHALL skip ACCESS and go directly from IDLE to DONE with err_o=1, rsp_data_o unchanged and no memory access (stall of 1 cycle).
REQ-027 With MEM_ALIGN_CHECK_EN undefined, err_o SHALL be constant 0 and all addresses SHALL proceed as in REQ-016.

Verification
REQ-028 Store 0xA1B2C3D4 to address 4 -> bytes 4..7 written as D4, C3, B2, A1 on 4 consecutive cycles; rsp_valid_o pulses in cycle 5.
REQ-029 Load from address 4 after REQ-028 -> rsp_data_o=0xA1B2C3D4 in DONE; stall_o high for 5 cycles.
REQ-030 Store 0x11223344 to address 30 (check off) -> bytes 30, 31, 0, 1 = 44, 33, 22, 11.
REQ-031 Assert rst_i=0 after 2 bytes of a store to address 8 -> outputs reset immediately; only bytes 8 and 9 are modified.
REQ-032 With MEM_ALIGN_CHECK_EN, load from address 6 -> no mem_read_o, err_o=1 with rsp_valid_o one cycle after acceptance.
REQ-033 Hold req_valid_i high for 12 cycles -> exactly two accesses complete, each followed by an IDLE cycle.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if -- request/response and byte-memory bus of the
// word-to-byte load/store sequencer.
//   slave  : the controller side (mem_access_ctrl)
//   master : the pipeline + data-memory side (EX/MEM stage, byte RAM)
// Request:  req_valid_i, req_write_i, req_addr_i, req_data_i
// Response: stall_o, rsp_valid_o, rsp_data_o, err_o
// Memory:   mem_write_o, mem_read_o, mem_addr_o, mem_data_o, mem_data_i
interface mem_access_ctrl_if;
  logic        req_valid_i;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        stall_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        err_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_data_i, mem_data_i,
    output stall_o, rsp_valid_o, rsp_data_o, err_o,
           mem_write_o, mem_read_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_data_i, mem_data_i,
    input  stall_o, rsp_valid_o, rsp_data_o, err_o,
           mem_write_o, mem_read_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- sequences a 32-bit load/store into four byte accesses
// on a byte-wide data memory of 2^ADDR_W bytes, little-endian, holding the
// pipeline via stall_o until the word is done.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : mem_access_ctrl_if.slave (request, response, memory bus)
// Optional feature: define MEM_ALIGN_CHECK_EN to reject requests with
// req_addr_i[1:0] != 0 (no memory access, one-cycle stall, err_o in DONE).
// Without it err_o is tied low and every address is sequenced.
module mem_access_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [23:0]       asm_q;   // low three load bytes; byte 3 goes straight to rsp_q
  logic [31:0]       rsp_q;
  logic              misaligned;
  logic [ADDR_W-1:0] byte_addr;

  // Only the low byte of the read port and the low ADDR_W address bits matter.
  logic unused_bits;
  assign unused_bits = ^{bus.mem_data_i[31:8], bus.req_addr_i[31:ADDR_W]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (bus.req_addr_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Wraps inside the memory: base 30 touches 30, 31, 0, 1.
  assign byte_addr = addr_q + ADDR_W'(cnt);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      asm_q  <= '0;
      rsp_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            wr_q   <= bus.req_write_i;
            addr_q <= bus.req_addr_i[ADDR_W-1:0];
            data_q <= bus.req_data_i;
            cnt    <= 2'd0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 2'd1;
          if (!wr_q) begin
            // rsp_q only changes when the whole word is in, so the previous
            // load result stays visible during the access.
            case (cnt)
              2'd0:    asm_q[7:0]   <= bus.mem_data_i[7:0];
              2'd1:    asm_q[15:8]  <= bus.mem_data_i[7:0];
              2'd2:    asm_q[23:16] <= bus.mem_data_i[7:0];
              default: rsp_q        <= {bus.mem_data_i[7:0], asm_q};
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           err_q <= 1'b0;
    else if (state == IDLE) err_q <= bus.req_valid_i & misaligned;
  end
  assign bus.err_o = err_q & (state == DONE);
`else
  assign bus.err_o = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    bus.stall_o     = 1'b0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_data_o  = rsp_q;
    bus.mem_write_o = 1'b0;
    bus.mem_read_o  = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = '0;
    case (state)
      IDLE: begin
        bus.stall_o = bus.req_valid_i;
        if (bus.req_valid_i) state_nxt = misaligned ? DONE : ACCESS;
      end
      ACCESS: begin
        bus.stall_o     = 1'b1;
        bus.mem_write_o = wr_q;
        bus.mem_read_o  = !wr_q;
        bus.mem_addr_o  = 32'(byte_addr);
        if (wr_q) bus.mem_data_o = {24'b0, data_q[{cnt, 3'b000} +: 8]};
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        // Always back through IDLE, so a request held high is not re-taken here.
        bus.rsp_valid_o = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();
  mem_access_ctrl #(.ADDR_W(5)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  // Byte-wide data memory attached to the DUT.
  logic [7:0] tb_mem [32] = '{default: 8'h00};
  always @(posedge clk) if (bus.mem_write_o) tb_mem[bus.mem_addr_o[4:0]] <= bus.mem_data_o[7:0];
  assign bus.mem_data_i = {24'hA5C3E1, tb_mem[bus.mem_addr_o[4:0]]};

  // Transaction-level reference: memory image plus last completed load word.
  logic [7:0]  ref_mem [32] = '{default: 8'h00};
  logic [31:0] ref_rsp = 32'h0;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) % 32);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) r = r | ({24'h0, ref_mem[wrap(a, k)]} << (8 * k));
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ref_mem[wrap(a, k)] = 8'(d >> (8 * k));
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   stalls = 0;
    int   nacc = 0;
    bit   done = 0;
    logic mis;
    mis = ALIGN_ON && (a[1:0] != 2'b00);
    if (!mis) begin
      if (w) ref_store(a, d);
      else   ref_rsp = ref_load(a);
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_write_i = w; bus.req_addr_i = a; bus.req_data_i = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.stall_o) stalls++;
      if (bus.mem_write_o || bus.mem_read_o) begin
        chk("acc_addr", bus.mem_addr_o, 32'(wrap(a, nacc)));
        chk("acc_dir", 32'({bus.mem_write_o, bus.mem_read_o}), w ? 32'd2 : 32'd1);
        if (w) chk("acc_wdata", bus.mem_data_o, (d >> (8 * nacc)) & 32'hFF);
        nacc++;
      end
      if (bus.rsp_valid_o) begin
        done = 1;
        chk("done_err", 32'(bus.err_o), 32'(mis));
        chk("done_rdata", bus.rsp_data_o, ref_rsp);
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    chk("stall_cycles", 32'(stalls), mis ? 32'd1 : 32'd5);
    chk("mem_cycles", 32'(nacc), mis ? 32'd0 : 32'd4);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("rsp_pulse", 32'(bus.rsp_valid_o), 32'd0);
    chk("idle_stall", 32'(bus.stall_o), 32'd0);
    chk("rsp_hold", bus.rsp_data_o, ref_rsp);
  endtask

  initial begin
    logic [31:0] a, d;
    int wr_seen, pulses, reads;
    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0;
    bus.req_addr_i = '0; bus.req_data_i = '0;

    // Reset state
    #12;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_data", bus.rsp_data_o, 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_mem_ctl", 32'({bus.mem_write_o, bus.mem_read_o}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Store then load back, plus a store wrapping the top of memory
    do_access(1'b1, 32'd4, 32'hA1B2C3D4);
    do_access(1'b0, 32'd4, 32'h0);
    chk("load_word4", bus.rsp_data_o, 32'hA1B2C3D4);
    do_access(1'b1, 32'd30, 32'h11223344);
    do_access(1'b0, 32'd28, 32'h0);

    // Reset after two bytes of a store to address 8
    d = $urandom;
    wr_seen = 0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_addr_i = 32'd8; bus.req_data_i = d;
    for (int c = 0; c < 10 && wr_seen < 2; c++) begin
      @(negedge clk);
      if (bus.mem_write_o) wr_seen++;
    end
    chk("abort_wr_seen", 32'(wr_seen), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.req_valid_i = 1'b0; #1;
    chk("abort_mem_write", 32'(bus.mem_write_o), 32'd0);
    chk("abort_mem_addr", bus.mem_addr_o, 32'd0);
    chk("abort_stall", 32'(bus.stall_o), 32'd0);
    chk("abort_rsp_data", bus.rsp_data_o, 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    ref_mem[8] = d[7:0]; ref_mem[9] = d[15:8]; ref_rsp = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    do_access(1'b0, 32'd8, 32'h0);

    // Request held for 12 cycles: two loads, each followed by IDLE
    a = $urandom & 32'hFFFF_FFFC;
    pulses = 0; reads = 0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_write_i = 1'b0; bus.req_addr_i = a;
    ref_rsp = ref_load(a);
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_read_o) reads++;
      if (bus.rsp_valid_o) begin
        pulses++;
        chk("held_rdata", bus.rsp_data_o, ref_rsp);
      end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_reads", 32'(reads), 32'd8);
    chk("held_idle_stall", 32'(bus.stall_o), 32'd0);

    // Randomized mix of loads and stores at arbitrary addresses
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), $urandom, $urandom);
    end

    for (int i = 0; i < 32; i++) chk("mem_image", 32'(tb_mem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
